// File: rtl/req_conditioner.sv
// Request front-end for the two-channel grant FSM: synchronises raw requests,
// turns rising edges into held requests, and counts edges lost to a busy channel.
module req_conditioner #(
  parameter int TIMEOUT = 8,
  parameter int TMO_W   = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       raw_req,
  input  logic [1:0]       gnt,
  output logic [1:0]       req,
  output logic [1:0]       timeout,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {IDLE, PEND} state_e;

  localparam logic [TMO_W-1:0] AGE_MAX = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [1:0]       sync1_q, sync2_q, prev_q;
  logic [1:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] age_q [2];
  logic [TMO_W-1:0] age_d [2];
  state_e           state_q [2];
  state_e           state_d [2];
  logic [1:0]       edge_w;
  logic [1:0]       drops_w;
  logic [CNT_W:0]   sum_w;

  // A clear (grant or timeout) that coincides with a new edge re-arms the
  // channel instead of dropping the edge; grant wins over timeout.
  always_comb begin
    edge_w  = sync2_q & ~prev_q;
    drops_w = 2'd0;
    tmo_d   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
      case (state_q[i])
        IDLE: begin
          if (edge_w[i]) begin
            state_d[i] = PEND;
            age_d[i]   = '0;
          end
        end
        PEND: begin
          if (gnt[i] || (age_q[i] == AGE_MAX)) begin
            tmo_d[i] = ~gnt[i];
            age_d[i] = '0;
            if (!edge_w[i]) state_d[i] = IDLE;
          end else begin
            age_d[i] = age_q[i] + TMO_W'(1);
            if (edge_w[i]) drops_w = drops_w + 2'd1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
    sum_w = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, drops_w};
    cnt_d = (sum_w > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_w[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
      tmo_q   <= 2'b00;
      cnt_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        age_q[i]   <= '0;
      end
    end else begin
      sync1_q <= raw_req;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  assign req      = {state_q[1] == PEND, state_q[0] == PEND};
  assign timeout  = tmo_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_req_conditioner.sv
// Self-checking bench for req_conditioner: hand-written vector table followed
// by model-scored sequences for timeout, drop saturation, collisions and reset.
module tb_req_conditioner;

  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] raw_req = 2'b00;
  logic [1:0] gnt = 2'b00;
  logic [1:0] req;
  logic [1:0] timeout;
  logic [3:0] drop_cnt;

  req_conditioner #(.TIMEOUT(TIMEOUT), .TMO_W(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .raw_req(raw_req), .gnt(gnt),
    .req(req), .timeout(timeout), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] tmo;
    logic [3:0] cnt;
  } expT;

  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] gnt;
    logic [1:0] eReq;
    logic [1:0] eTmo;
    logic [3:0] eCnt;
  } vecT;

  expT   sbQ[$];
  string labelQ[$];
  int    checks = 0;
  int    passes = 0;

  // Reference model: behaviour written from the request description.
  logic [1:0] mS1 = 2'b00, mS2 = 2'b00, mPrev = 2'b00, mPend = 2'b00;
  int mAge[2] = '{0, 0};
  int mCnt = 0;

  task automatic modelStep(input logic rst, input logic [1:0] raw,
                           input logic [1:0] g, output expT e);
    logic [1:0] rise;
    logic [1:0] tmo;
    int drops;
    tmo = 2'b00;
    if (rst) begin
      mS1 = 2'b00; mS2 = 2'b00; mPrev = 2'b00; mPend = 2'b00;
      mAge[0] = 0; mAge[1] = 0; mCnt = 0;
    end else begin
      rise  = mS2 & ~mPrev;
      drops = 0;
      for (int i = 0; i < 2; i++) begin
        if (!mPend[i]) begin
          if (rise[i]) begin mPend[i] = 1'b1; mAge[i] = 0; end
        end else if (g[i] || mAge[i] == TIMEOUT - 1) begin
          if (!g[i]) tmo[i] = 1'b1;
          if (rise[i]) mAge[i] = 0;
          else mPend[i] = 1'b0;
        end else begin
          mAge[i] = mAge[i] + 1;
          if (rise[i]) drops = drops + 1;
        end
      end
      mCnt  = (mCnt + drops > CNT_MAX) ? CNT_MAX : mCnt + drops;
      mPrev = mS2; mS2 = mS1; mS1 = raw;
    end
    e.req = mPend;
    e.tmo = tmo;
    e.cnt = 4'(mCnt);
  endtask

  task automatic checkOutput(input string name, input expT got, input expT exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got req=%b tmo=%b cnt=%0d, required req=%b tmo=%b cnt=%0d",
                  name, got.req, got.tmo, got.cnt, exp.req, exp.tmo, exp.cnt);
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] raw, input logic [1:0] g,
                               input string label, input bit useTbl, input expT tblExp);
    expT e;
    expT got;
    string lbl;
    modelStep(rst, raw, g, e);
    sbQ.push_back(useTbl ? tblExp : e);
    labelQ.push_back(label);
    reset   = rst;
    raw_req = raw;
    gnt     = g;
    @(posedge clock);
    #1;
    got = {req, timeout, drop_cnt};
    e   = sbQ.pop_front();
    lbl = labelQ.pop_front();
    checkOutput(lbl, got, e);
  endtask

  task automatic step(input logic rst, input logic [1:0] raw, input logic [1:0] g,
                      input string label);
    applyStimulus(rst, raw, g, label, 1'b0, '0);
  endtask

  vecT vecs[12];
  int  hiCnt, pulseCnt;

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[7]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 4'd0};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'd0};
    vecs[9]  = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 4'd0};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0};
    vecs[11] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 4'd0};

    for (int k = 0; k < 12; k++)
      applyStimulus(vecs[k].rst, vecs[k].raw, vecs[k].gnt, $sformatf("vec%0d", k), 1'b1,
                    {vecs[k].eReq, vecs[k].eTmo, vecs[k].eCnt});

    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, 2'b00, "rst_hold11");
    for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 2'b00, "rst_release11");
    for (int k = 0; k < 12; k++) step(1'b0, 2'b00, 2'b00, "rst_release_drain");

    // Ungranted request on channel 1 must be held exactly TIMEOUT cycles.
    step(1'b1, 2'b00, 2'b00, "tmo_reset");
    step(1'b0, 2'b10, 2'b00, "tmo_pulse");
    hiCnt = 0; pulseCnt = 0;
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 2'b00, 2'b00, "tmo_run");
      if (req[1]) hiCnt++;
      if (timeout == 2'b10) pulseCnt++;
    end
    checkInt("tmo_hold_len", hiCnt, TIMEOUT);
    checkInt("tmo_pulse_count", pulseCnt, 1);
    checkInt("tmo_req_after", int'(req), 0);

    step(1'b1, 2'b00, 2'b00, "drop1_reset");
    for (int k = 0; k < 60; k++) step(1'b0, {1'b0, ~k[0]}, 2'b00, "drop1_toggle");
    checkInt("drop1_saturated", int'(drop_cnt), CNT_MAX);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b00, 2'b00, "drop1_hold");
    checkInt("drop1_holds", int'(drop_cnt), CNT_MAX);

    // Both channels drop in lock-step, so the count steps by two and must
    // land on the maximum from 14 instead of wrapping.
    step(1'b1, 2'b00, 2'b00, "drop2_reset");
    for (int k = 0; k < 40; k++) step(1'b0, {2{~k[0]}}, 2'b00, "drop2_toggle");
    checkInt("drop2_saturated", int'(drop_cnt), CNT_MAX);

    step(1'b1, 2'b00, 2'b00, "coll_reset");
    step(1'b0, 2'b01, 2'b00, "coll_arm");
    step(1'b0, 2'b00, 2'b00, "coll_sync");
    step(1'b0, 2'b00, 2'b00, "coll_pend");
    step(1'b0, 2'b01, 2'b00, "coll_rise2");
    step(1'b0, 2'b00, 2'b00, "coll_sync2");
    step(1'b0, 2'b00, 2'b01, "coll_gnt_edge");
    checkInt("coll_rearm_req", int'(req[0]), 1);
    checkInt("coll_rearm_cnt", int'(drop_cnt), 0);
    hiCnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b00, 2'b00, "coll_age_restart");
      if (req[0]) hiCnt++;
    end
    checkInt("coll_rearm_len", hiCnt, TIMEOUT - 1);

    step(1'b0, 2'b01, 2'b00, "gnt_last_arm");
    step(1'b0, 2'b00, 2'b00, "gnt_last_sync");
    step(1'b0, 2'b00, 2'b00, "gnt_last_pend");
    for (int k = 0; k < TIMEOUT - 1; k++) step(1'b0, 2'b00, 2'b00, "gnt_last_age");
    pulseCnt = 0;
    step(1'b0, 2'b00, 2'b01, "gnt_last_grant");
    if (timeout != 2'b00) pulseCnt++;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b00, 2'b00, "gnt_last_after");
      if (timeout != 2'b00) pulseCnt++;
    end
    checkInt("gnt_beats_timeout", pulseCnt, 0);

    step(1'b1, 2'b00, 2'b00, "mid_reset0");
    step(1'b0, 2'b11, 2'b00, "mid_arm");
    step(1'b0, 2'b00, 2'b00, "mid_sync");
    step(1'b0, 2'b00, 2'b00, "mid_pend");
    step(1'b0, 2'b11, 2'b00, "mid_age1");
    step(1'b0, 2'b00, 2'b00, "mid_age2");
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 2'b00, "mid_age");
    checkInt("mid_pre_req", int'(req), 3);
    checkInt("mid_pre_cnt", int'(drop_cnt), 2);
    step(1'b1, 2'b00, 2'b00, "mid_reset");
    checkInt("mid_req", int'(req), 0);
    checkInt("mid_cnt", int'(drop_cnt), 0);
    pulseCnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'b00, 2'b00, "mid_after");
      if (timeout != 2'b00 || req != 2'b00) pulseCnt++;
    end
    checkInt("mid_quiet", pulseCnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
